// File: rtl/line_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_ctrl_pkg
// Brief    : Shared line geometry constants and fill-controller state encoding.
// Revision : 1.0
// ============================================================================
package line_fill_ctrl_pkg;

    localparam int LINE_BITS   = 512;
    localparam int LINE_WORDS  = 16;
    localparam int WORD_BITS   = 32;
    localparam int OFFSET_BITS = 6;
    localparam int WIDX_BITS   = OFFSET_BITS - 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_RESP      = 3'd3,
        ST_WAIT_DROP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_ctrl
// Brief    : Fills one cache line from a fixed-latency word SRAM and hands it
//            back to the requester with a single-cycle ready pulse.
// Revision : 1.0
// ============================================================================
module line_fill_ctrl
    import line_fill_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int SRAM_LAT   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mem_addr_valid,
    input  logic [31:0]                       mem_addr,
    output logic                              mem_data_ready,
    output logic [LINE_WORDS*WORD_BITS-1:0]   mem_data_o,
    output logic                              sram_rd_en,
    output logic [31:0]                       sram_addr,
    input  logic [31:0]                       sram_rd_data,
    output logic                              busy
);

    localparam logic [WIDX_BITS-1:0] LAST_WORD = WIDX_BITS'(LINE_WORDS - 1);

    state_t                          state;
    state_t                          state_nxt;
    logic [31-OFFSET_BITS:0]         line_addr;
    logic [WIDX_BITS-1:0]            issue_cnt;
    logic [WIDX_BITS-1:0]            capture_cnt;
    logic [SRAM_LAT-1:0]             rd_pipe;
    logic [LINE_WORDS*WORD_BITS-1:0] line_q;
    logic                            accept;
    logic                            capture;
    logic                            unused_offset;

    assign unused_offset = ^mem_addr[OFFSET_BITS-1:0];
    assign capture       = rd_pipe[SRAM_LAT-1];
    assign busy          = (state != ST_IDLE);
    assign mem_data_o    = line_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        sram_rd_en     = 1'b0;
        sram_addr      = '0;
        mem_data_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_addr_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                sram_rd_en = 1'b1;
                sram_addr  = {line_addr, issue_cnt, 2'b00};
                if (issue_cnt == LAST_WORD) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (capture && (capture_cnt == LAST_WORD)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                // An abandoned request gets no pulse; the line is simply dropped.
                if (mem_addr_valid) begin
                    mem_data_ready = 1'b1;
                    state_nxt      = ST_WAIT_DROP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DROP: begin
                if (!mem_addr_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read-valid delay line; clearing it on reset discards in-flight SRAM data.
    generate
        if (SRAM_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= sram_rd_en;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= {rd_pipe[SRAM_LAT-2:0], sram_rd_en};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_addr   <= '0;
            issue_cnt   <= '0;
            capture_cnt <= '0;
            line_q      <= '0;
        end else begin
            if (accept) begin
                line_addr   <= mem_addr[31:OFFSET_BITS];
                issue_cnt   <= '0;
                capture_cnt <= '0;
            end else if (sram_rd_en) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (capture) begin
                line_q[capture_cnt*WORD_BITS +: WORD_BITS] <= sram_rd_data;
                capture_cnt                                <= capture_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fill_ctrl
// Brief    : Scoreboard bench driving LAT=1 and LAT=3 fill controllers in lockstep.
// Revision : 1.0
// ============================================================================
module tb_line_fill_ctrl;

    typedef struct {
        logic [31:0] a;
        int          c;
    } rd_t;

    typedef struct {
        logic [511:0] d;
        int           c;
    } rs_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_addr_valid;
    logic [31:0]  mem_addr;

    logic         rdy1, en1, busy1;
    logic [511:0] data1;
    logic [31:0]  addr1, rdd1;
    logic         rdy3, en3, busy3;
    logic [511:0] data3;
    logic [31:0]  addr3, rdd3;

    rd_t rq1[$], rq3[$];
    rs_t sq1[$], sq3[$];
    rd_t r1, r3;
    rs_t s1, s3;
    int  srv1 = 0, srv3 = 0;
    int  cyc = 0;
    int  n_vec = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_fill_ctrl #(.LINE_WORDS(16), .SRAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .mem_addr_valid(mem_addr_valid), .mem_addr(mem_addr),
        .mem_data_ready(rdy1), .mem_data_o(data1), .sram_rd_en(en1),
        .sram_addr(addr1), .sram_rd_data(rdd1), .busy(busy1)
    );

    line_fill_ctrl #(.LINE_WORDS(16), .SRAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .mem_addr_valid(mem_addr_valid), .mem_addr(mem_addr),
        .mem_data_ready(rdy3), .mem_data_o(data3), .sram_rd_en(en3),
        .sram_addr(addr3), .sram_rd_data(rdd3), .busy(busy3)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Expected line: word k of the 64-byte line containing req.
    function automatic logic [511:0] exp_line(input logic [31:0] req);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) begin
            l[32*k +: 32] = 32'hA000_0000 + (req >> 6) * 32'd16 + 32'(k);
        end
        return l;
    endfunction

    // SRAM models; garbage outside valid windows exposes mistimed captures.
    logic [31:0] h1;
    logic [31:0] h3 [3];
    always @(posedge clk) begin
        h1    <= en1 ? sram_word(addr1) : 32'hDEAD_BEEF;
        h3[0] <= en3 ? sram_word(addr3) : 32'hDEAD_BEEF;
        h3[1] <= h3[0];
        h3[2] <= h3[1];
    end
    assign rdd1 = h1;
    assign rdd3 = h3[2];

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitors: pop expectations whenever a DUT presents a read or a ready.
    always @(negedge clk) begin
        if (en1) begin
            if (rq1.size() == 0) chk("dut1 unexpected read", 1, 0);
            else begin
                r1 = rq1.pop_front();
                chk("dut1 read addr", addr1, r1.a);
                chk("dut1 read cycle", cyc, r1.c);
            end
        end
        if (rdy1) begin
            srv1++;
            if (sq1.size() == 0) chk("dut1 unexpected ready", 1, 0);
            else begin
                s1 = sq1.pop_front();
                chk_w("dut1 line data", data1, s1.d);
                chk("dut1 ready cycle", cyc, s1.c);
            end
        end
        if (en3) begin
            if (rq3.size() == 0) chk("dut3 unexpected read", 1, 0);
            else begin
                r3 = rq3.pop_front();
                chk("dut3 read addr", addr3, r3.a);
                chk("dut3 read cycle", cyc, r3.c);
            end
        end
        if (rdy3) begin
            srv3++;
            if (sq3.size() == 0) chk("dut3 unexpected ready", 1, 0);
            else begin
                s3 = sq3.pop_front();
                chk_w("dut3 line data", data3, s3.d);
                chk("dut3 ready cycle", cyc, s3.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int t0, input logic [31:0] a, input int nreads, input bit resp);
        rd_t r;
        rs_t s;
        for (int k = 0; k < nreads; k++) begin
            r.a = (a & ~32'h3F) + 32'(4 * k);
            r.c = t0 + 1 + k;
            rq1.push_back(r);
            rq3.push_back(r);
        end
        if (resp) begin
            s.d = exp_line(a);
            s.c = t0 + 18;
            sq1.push_back(s);
            s.c = t0 + 20;
            sq3.push_back(s);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy3) && n < 200) begin
            tick();
            n++;
        end
        chk("idle before request", int'(busy1 | busy3), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " dut1 rd_en"}, int'(en1), 0);
        chk({tag, " dut1 sram_addr"}, addr1, 0);
        chk({tag, " dut1 ready"}, int'(rdy1), 0);
        chk({tag, " dut1 busy"}, int'(busy1), 0);
        chk_w({tag, " dut1 data"}, data1, '0);
        chk({tag, " dut3 rd_en"}, int'(en3), 0);
        chk({tag, " dut3 sram_addr"}, addr3, 0);
        chk({tag, " dut3 ready"}, int'(rdy3), 0);
        chk({tag, " dut3 busy"}, int'(busy3), 0);
        chk_w({tag, " dut3 data"}, data3, '0);
    endtask

    task automatic do_req(input logic [31:0] a, input int hold);
        int t0, b1, b3, n;
        wait_idle();
        t0 = cyc;
        b1 = srv1;
        b3 = srv3;
        mem_addr_valid = 1'b1;
        mem_addr       = a;
        push_exp(t0, a, 16, 1'b1);
        n = 0;
        while ((srv1 == b1 || srv3 == b3) && n < 60) begin
            tick();
            mem_addr = $urandom;
            n++;
        end
        chk("dut1 served once", srv1 - b1, 1);
        chk("dut3 served once", srv3 - b3, 1);
        repeat (hold) tick();
        mem_addr_valid = 1'b0;
        tick();
    endtask

    task automatic do_abandon(input logic [31:0] a, input int drop);
        int t0, b1, b3;
        wait_idle();
        t0 = cyc;
        b1 = srv1;
        b3 = srv3;
        mem_addr_valid = 1'b1;
        mem_addr       = a;
        push_exp(t0, a, 16, 1'b0);
        while (cyc < t0 + drop) tick();
        mem_addr_valid = 1'b0;
        while (cyc < t0 + 19) tick();
        chk("abandon dut1 busy", int'(busy1), 0);
        tick();
        tick();
        chk("abandon dut3 busy", int'(busy3), 0);
        chk("abandon dut1 no ready", srv1 - b1, 0);
        chk("abandon dut3 no ready", srv3 - b3, 0);
    endtask

    task automatic do_reset_mid(input logic [31:0] a, input int at);
        int t0;
        wait_idle();
        t0 = cyc;
        mem_addr_valid = 1'b1;
        mem_addr       = a;
        push_exp(t0, a, at, 1'b0);
        while (cyc < t0 + at) tick();
        rst            = 1'b0;
        mem_addr_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid-fill reset");
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        mem_addr_valid = 1'b0;
        mem_addr       = '0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        do_req(32'h0000_0040, 0);
        do_req(32'h0000_007F, 0);
        do_req(32'h0000_0040, 5);
        do_abandon(32'h0000_0040, 10);
        do_reset_mid(32'h0000_0080, 8);
        do_req(32'h0000_0000, 0);
        do_req(32'hFFFF_FFC5, 1);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_req($urandom, $urandom_range(0, 4));
        end

        repeat (30) tick();
        chk("dut1 reads outstanding", rq1.size(), 0);
        chk("dut3 reads outstanding", rq3.size(), 0);
        chk("dut1 responses outstanding", sq1.size(), 0);
        chk("dut3 responses outstanding", sq3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
